ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter; the companion to the existing PS/2 keyboard receiver.
- Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the shared open-drain ps2_clk/ps2_data lines.
- Runs the full host-request sequence: clock inhibit, start bit, 8 data bits LSB-first, odd parity, stop bit, device ACK.
- Sits beside the receiver; the receiver must ignore the bus while tx_busy=1.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_edge_sync.sv | 33 +++
 rtl/ps2_host_tx.sv | 206 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter.
//   ps2_tx_state_e : transmitter FSM states
//   FRAME_BITS     : bits shifted out after the start bit (8 data + parity + stop)
//   ACK_FALL       : device clock fall on which the ACK bit is sampled
//   odd_parity()   : parity bit that makes the 9-bit {parity, data} word odd
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RELEASE,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_e;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned ACK_FALL   = 11;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Three-flop synchronizer for one raw PS/2 line, plus a falling-edge pulse.
//   clk      : system clock
//   rst      : synchronous reset, active-high (flops preset to the idle-high bus level)
//   async_in : raw pin value
//   sync_out : synchronized level (oldest stage)
//   fall     : one-cycle pulse when the synchronized level goes 1 -> 0
module ps2_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic fall
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q[2];
  assign fall     = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues the start bit,
// shifts out 8 data bits LSB-first, odd parity and stop on device clock falls,
// then samples the device ACK and waits for the bus to go idle.
//   clk, rst               : system clock, synchronous active-high reset
//   tx_data/tx_valid       : command byte and request (accepted when tx_ready)
//   tx_ready/tx_busy       : IDLE / not IDLE
//   tx_done/tx_err         : one-cycle completion pulse, error on missing ACK or timeout
//   ps2_clk_in/ps2_data_in : raw open-drain pin values
//   ps2_clk_oe/ps2_data_oe : 1 pulls the line low
// Optional: define PS2_TX_TIMEOUT_EN to add a per-transfer watchdog of
// TIMEOUT_CYCLES clk cycles.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned BC_W  = $clog2(ACK_FALL);

  logic clk_sync, clk_fall, data_sync;
  // Edges on the data line carry no meaning for the transmitter.
  logic data_fall_unused;

  ps2_edge_sync u_clk_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ps2_clk_in),
    .sync_out (clk_sync),
    .fall     (clk_fall)
  );

  ps2_edge_sync u_data_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ps2_data_in),
    .sync_out (data_sync),
    .fall     (data_fall_unused)
  );

  ps2_tx_state_e          state_q, state_d;
  logic                   clk_oe_q, clk_oe_d;
  logic                   data_oe_q, data_oe_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   ack_err_q, ack_err_d;
  logic [BC_W-1:0]        bitcnt_q, bitcnt_d;
  logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
  logic [INH_W-1:0]       inh_cnt_q, inh_cnt_d;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`else
  localparam int unsigned TIMEOUT_CYCLES_UNUSED = TIMEOUT_CYCLES;
`endif

  logic inh_last;
  logic inh_penult;

  assign inh_last   = (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1));
  // oe outputs are registered, so the start bit is requested one cycle
  // early to be on the line during the final inhibit cycle.
  assign inh_penult = ((32'(inh_cnt_q) + 32'd2) >= INHIBIT_CYCLES);

  always_comb begin
    state_d   = state_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    ack_err_d = ack_err_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    inh_cnt_d = inh_cnt_q;
`ifdef PS2_TX_TIMEOUT_EN
    wd_cnt_d  = wd_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          shreg_d   = {1'b1, odd_parity(tx_data), tx_data};
          bitcnt_d  = '0;
          inh_cnt_d = '0;
          ack_err_d = 1'b0;
          clk_oe_d  = 1'b1;
          data_oe_d = (INHIBIT_CYCLES <= 1);
          state_d   = INHIBIT;
`ifdef PS2_TX_TIMEOUT_EN
          wd_cnt_d  = '0;
`endif
        end
      end
      INHIBIT: begin
        if (inh_last) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = RELEASE;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
          data_oe_d = inh_penult;
        end
      end
      RELEASE: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        if (clk_fall) begin
          data_oe_d = ~shreg_q[0];
          shreg_d   = {1'b0, shreg_q[FRAME_BITS-1:1]};
          bitcnt_d  = bitcnt_q + BC_W'(1);
          if (bitcnt_q == BC_W'(FRAME_BITS - 1)) begin
            state_d = ACK;
          end
        end
      end
      ACK: begin
        if (clk_fall) begin
          ack_err_d = data_sync;
          bitcnt_d  = bitcnt_q + BC_W'(1);
          state_d   = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          err_d   = ack_err_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog overrides whatever the FSM decided this cycle.
    if (state_q != IDLE) begin
      if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        done_d    = 1'b1;
        err_d     = 1'b1;
        state_d   = IDLE;
      end else begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ack_err_q <= 1'b0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      inh_cnt_q <= '0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ack_err_q <= ack_err_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      inh_cnt_q <= inh_cnt_d;
`ifdef PS2_TX_TIMEOUT_EN
      wd_cnt_q  <= wd_cnt_d;
`endif
    end
  end

  assign tx_ready    = (state_q == IDLE);
  assign tx_busy     = (state_q != IDLE);
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a keyboard model that clocks the
// frame in (half period H clk cycles), samples data on rising edges and
// drives ACK on the 11th clock. Expected bytes/error flags are queued when a
// request is issued and compared as the device receives and the host finishes.
module tb_ps2_host_tx;

  localparam int unsigned INH = 20;
  localparam int unsigned TMO = 500;
  localparam int          H   = 10;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk  = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   hold_valid = 1'b0;
  logic ready_bad  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_parity(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      ready_bad = ready_bad | tx_ready;
    end
  endtask

  task automatic start_tx(input logic [7:0] d, input logic err);
    exp_t e;
    @(negedge clk);
    tx_data   = d;
    tx_valid  = 1'b1;
    ready_bad = 1'b0;
    e.data = d;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic device_frame(input bit ack, input bit poke, input bit abort5);
    int         n;
    logic [9:0] got;
    logic       last_doe;
    exp_t       e;
    got = '0;
    n = 0;
    while (!ps2_clk_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ps2_clk_oe) begin
      check("accept_seen", 0, 1);
      return;
    end
    if (!hold_valid) tx_valid = 1'b0;
    n = 0;
    last_doe = 1'b0;
    while (ps2_clk_oe && n < 100) begin
      last_doe = ps2_data_oe;
      tick(1);
      n++;
    end
    check("inhibit_len", n, INH);
    check("start_in_inhibit", last_doe, 1);
    check("start_bit_line", ps2_data_in, 0);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = exp_q[0];
    tick(H);
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      if (abort5 && k == 5) begin
        tick(H / 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_done", {tx_done, tx_err}, 0);
        dev_clk = 1'b1;
        n = 0;
        repeat (4 * H) begin
          @(negedge clk);
          if (tx_done) n++;
        end
        check("rst_no_done", n, 0);
        void'(exp_q.pop_front());
        return;
      end
      if (poke && k == 3) begin
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(H - 1);
      end else begin
        tick(H);
      end
      dev_clk = 1'b1;
      if (k <= 10) got[k-1] = ps2_data_in;
      if (k == 10) dev_data = ack ? 1'b0 : 1'b1;
      if (k == 11) dev_data = 1'b1;
      if (k < 11) tick(H);
    end
    check("frame_data", got[7:0], e.data);
    check("frame_parity", got[8], exp_parity(e.data));
    check("frame_stop", got[9], 1);
  endtask

  task automatic wait_done();
    int   n;
    exp_t e;
    n = 0;
    while (!tx_done && n < 200) begin
      @(negedge clk);
      n++;
      if (!tx_done) ready_bad = ready_bad | tx_ready;
    end
    check("done_seen", tx_done, 1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check("err_flag", tx_err, e.err);
    check("oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
    check("ready_at_done", tx_ready, 1);
    check("busy_at_done", tx_busy, 0);
    check("ready_low_busy", ready_bad, 0);
    ready_bad = 1'b0;
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ready", tx_ready, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("reset_done_err", {tx_done, tx_err}, 0);
    rst = 1'b0;
    tick(3);

    // Single command with ACK.
    start_tx(8'hED, 1'b0);
    device_frame(1'b1, 1'b0, 1'b0);
    wait_done();

    // Back-to-back with tx_valid held; next byte presented on the tx_done cycle.
    hold_valid = 1'b1;
    start_tx(8'h00, 1'b0);
    device_frame(1'b1, 1'b0, 1'b0);
    wait_done();
    tx_data = 8'hFF;
    exp_q.push_back('{data: 8'hFF, err: 1'b0});
    @(negedge clk);
    check("b2b_accept_ff", ps2_clk_oe, 1);
    device_frame(1'b1, 1'b0, 1'b0);
    wait_done();
    tx_data = 8'h01;
    exp_q.push_back('{data: 8'h01, err: 1'b0});
    hold_valid = 1'b0;
    @(negedge clk);
    check("b2b_accept_01", ps2_clk_oe, 1);
    device_frame(1'b1, 1'b0, 1'b0);
    wait_done();

    // Missing ACK.
    start_tx(8'h3C, 1'b1);
    device_frame(1'b0, 1'b0, 1'b0);
    wait_done();

    // Reset mid-frame, then a clean transfer.
    start_tx(8'hA5, 1'b0);
    device_frame(1'b1, 1'b0, 1'b1);
    tick(2 * H);
    start_tx(8'h5A, 1'b0);
    device_frame(1'b1, 1'b0, 1'b0);
    wait_done();

    // Request pulsed while busy is ignored; tx_data changes have no effect.
    start_tx(8'h34, 1'b0);
    device_frame(1'b1, 1'b1, 1'b0);
    wait_done();
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (ps2_clk_oe) n++;
    end
    check("no_extra_tx", n, 0);

`ifdef PS2_TX_TIMEOUT_EN
    // Silent device: watchdog ends the transfer TMO cycles after acceptance.
    @(negedge clk);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    n = 0;
    while (!ps2_clk_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    tx_valid = 1'b0;
    check("tmo_accept", ps2_clk_oe, 1);
    n = 0;
    while (!tx_done && n < 2 * TMO) begin
      @(negedge clk);
      n++;
    end
    check("tmo_latency", n, TMO);
    check("tmo_err", {tx_done, tx_err}, 2'b11);
    check("tmo_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    @(negedge clk);
    check("tmo_idle", tx_ready, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
